// File: rtl/axibram_rd_devmux.sv
// axibram_rd_devmux: steers an AXI BRAM read engine across NUM_DEV devices with a
// select pipeline matched to ren/regen and a ready watchdog that drains hung bursts.
module axibram_rd_devmux #(
  parameter int ADDRESS_BITS = 10,
  parameter int SEL_BITS = 2,
  parameter int NUM_DEV = 4,
  parameter int TIMEOUT_BITS = 8,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic aclk,
  input  logic rst,
  input  logic [ADDRESS_BITS-1:0] pre_araddr,
  input  logic start_burst,
  input  logic [ADDRESS_BITS-1:0] bram_raddr,
  input  logic bram_ren,
  input  logic bram_regen,
  output logic dev_ready,
  output logic [31:0] bram_rdata,
  output logic [ADDRESS_BITS-SEL_BITS-1:0] dev_raddr,
  output logic [NUM_DEV-1:0] dev_ren,
  output logic [NUM_DEV-1:0] dev_regen,
  input  logic [NUM_DEV-1:0] dev_rdy_in,
  input  logic [32*NUM_DEV-1:0] dev_rdata,
  output logic timeout_err,
  input  logic clr_err
);
  localparam int NS = 2**SEL_BITS;
  logic [SEL_BITS-1:0] sel_q, sel_d, sel_d1_q, sel_d1_d, sel_d2_q, sel_d2_d;
  logic to_d1_q, to_d1_d, to_d2_q, to_d2_d, err_q, err_d;
  logic [TIMEOUT_BITS-1:0] wd_cnt_q, wd_cnt_d;
  logic [NS-1:0] mapped, rdy_pad;
  logic [31:0] rdata_arr [NS];
  logic wd_expired, unused_addr;
  // Pad per-device vectors to the full select range so unmapped selects index safely.
  for (genvar g = 0; g < NS; g++) begin : g_dev
    if (g < NUM_DEV) begin : g_m
      assign mapped[g] = 1'b1;
      assign rdy_pad[g] = dev_rdy_in[g];
      assign rdata_arr[g] = dev_rdata[32*g +: 32];
      assign dev_ren[g] = bram_ren & (sel_q == SEL_BITS'(g)) & ~wd_expired;
      assign dev_regen[g] = bram_regen & (sel_d1_q == SEL_BITS'(g));
    end else begin : g_u
      assign mapped[g] = 1'b0;
      assign rdy_pad[g] = 1'b0;
      assign rdata_arr[g] = '0;
    end
  end
  assign unused_addr = ^{bram_raddr[ADDRESS_BITS-1 -: SEL_BITS], pre_araddr[ADDRESS_BITS-SEL_BITS-1:0]};
  assign wd_expired = &wd_cnt_q;
  assign dev_raddr = bram_raddr[ADDRESS_BITS-SEL_BITS-1:0];
  assign dev_ready = ~mapped[sel_q] | wd_expired | rdy_pad[sel_q];
  assign timeout_err = err_q;
  assign bram_rdata = to_d2_q ? (mapped[sel_d2_q] ? TIMEOUT_DATA : 32'h0) : rdata_arr[sel_d2_q];
  always_comb begin
    sel_d = start_burst ? pre_araddr[ADDRESS_BITS-1 -: SEL_BITS] : sel_q;
    sel_d1_d = bram_ren ? sel_q : sel_d1_q;
    to_d1_d = bram_ren ? (wd_expired | ~mapped[sel_q]) : to_d1_q;
    sel_d2_d = bram_regen ? sel_d1_q : sel_d2_q;
    to_d2_d = bram_regen ? to_d1_q : to_d2_q;
    wd_cnt_d = (start_burst | rdy_pad[sel_q] | ~mapped[sel_q]) ? '0 :
               wd_expired ? wd_cnt_q : wd_cnt_q + 1'b1;
    // Error sets only on the transition into saturation so clr_err works while still expired.
    err_d = (&wd_cnt_d & ~wd_expired) | (err_q & ~clr_err);
  end
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
      sel_d1_q <= '0;
      sel_d2_q <= '0;
      to_d1_q <= 1'b0;
      to_d2_q <= 1'b0;
      wd_cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      sel_d1_q <= sel_d1_d;
      sel_d2_q <= sel_d2_d;
      to_d1_q <= to_d1_d;
      to_d2_q <= to_d2_d;
      wd_cnt_q <= wd_cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_axibram_rd_devmux.sv
// tb_axibram_rd_devmux: directed bench with two-stage BRAM device models behind the mux.
module tb_axibram_rd_devmux;
  logic aclk, rst, start_burst, bram_ren, bram_regen, clr_err;
  logic [9:0] pre_araddr, bram_raddr;
  logic [3:0] dev_rdy;
  logic [127:0] dev_rdata;
  logic rdy, terr, rdy3, terr3;
  logic [31:0] rdata, rdata3;
  logic [7:0] draddr, draddr3;
  logic [3:0] dren, drgen;
  logic [2:0] dren3, drgen3;
  logic [31:0] st1 [4];
  logic [31:0] outr [4];
  int n_run, n_fail;

  axibram_rd_devmux dut (
    .aclk(aclk), .rst(rst), .pre_araddr(pre_araddr), .start_burst(start_burst),
    .bram_raddr(bram_raddr), .bram_ren(bram_ren), .bram_regen(bram_regen),
    .dev_ready(rdy), .bram_rdata(rdata), .dev_raddr(draddr), .dev_ren(dren),
    .dev_regen(drgen), .dev_rdy_in(dev_rdy), .dev_rdata(dev_rdata),
    .timeout_err(terr), .clr_err(clr_err));

  axibram_rd_devmux #(.NUM_DEV(3)) dut3 (
    .aclk(aclk), .rst(rst), .pre_araddr(pre_araddr), .start_burst(start_burst),
    .bram_raddr(bram_raddr), .bram_ren(bram_ren), .bram_regen(bram_regen),
    .dev_ready(rdy3), .bram_rdata(rdata3), .dev_raddr(draddr3), .dev_ren(dren3),
    .dev_regen(drgen3), .dev_rdy_in(dev_rdy[2:0]), .dev_rdata(dev_rdata[95:0]),
    .timeout_err(terr3), .clr_err(clr_err));

  function automatic logic [31:0] word(input int dev, input logic [7:0] a);
    return {8'(dev + 1), 8'h5A, 8'h00, a};
  endfunction

  always_ff @(posedge aclk) begin
    for (int i = 0; i < 4; i++) begin
      if (dren[i]) st1[i] <= word(i, draddr);
      if (drgen[i]) outr[i] <= st1[i];
    end
  end
  assign dev_rdata = {outr[3], outr[2], outr[1], outr[0]};

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic d(input logic s, input logic [9:0] pa, input logic rn, input logic rg, input logic [9:0] ra);
    start_burst = s;
    pre_araddr = pa;
    bram_ren = rn;
    bram_regen = rg;
    bram_raddr = ra;
    #1;
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    rst = 1'b1;
    clr_err = 1'b0;
    dev_rdy = 4'hF;
    d(0, 0, 0, 0, 0);
    #10;
    chk("rst_err", 32'(terr), 0);
    chk("rst_ren", 32'(dren), 0);
    chk("rst_regen", 32'(drgen), 0);
    chk("rst_rdy", 32'(rdy), 1);
    rst = 1'b0;
    tick();
    // burst to device 2 with full-rate ren/regen
    d(1, 10'h2A0, 0, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      d(0, 0, 1, 1, 10'(10'h2A0 + k));
      chk("t1_ren", 32'(dren), 32'h4);
      chk("t1_raddr", 32'(draddr), 32'(8'hA0 + k));
      tick();
      if (k >= 1) chk("t1_data", rdata, word(2, 8'(8'hA0 + k - 1)));
    end
    d(0, 0, 0, 1, 0);
    tick();
    chk("t1_drain", rdata, word(2, 8'hA3));
    // back-to-back: device 1 then device 3, new start on last ren
    d(1, 10'h100, 0, 0, 0);
    tick();
    d(0, 0, 1, 1, 10'h100);
    tick();
    d(0, 0, 1, 1, 10'h101);
    tick();
    chk("t2_d0", rdata, word(1, 8'h00));
    d(1, 10'h300, 1, 1, 10'h102);
    chk("t2_oldsel_ren", 32'(dren), 32'h2);
    tick();
    chk("t2_d1", rdata, word(1, 8'h01));
    d(0, 0, 1, 1, 10'h300);
    chk("t2_ren3", 32'(dren), 32'h8);
    chk("t2_regen1", 32'(drgen), 32'h2);
    tick();
    chk("t2_d2", rdata, word(1, 8'h02));
    d(0, 0, 1, 1, 10'h301);
    chk("t2_regen3", 32'(drgen), 32'h8);
    tick();
    chk("t2_d3", rdata, word(3, 8'h00));
    d(0, 0, 0, 1, 0);
    tick();
    chk("t2_d4", rdata, word(3, 8'h01));
    // stall mid-burst on device 0
    d(1, 10'h000, 0, 0, 0);
    tick();
    d(0, 0, 1, 1, 10'h005);
    tick();
    d(0, 0, 1, 1, 10'h006);
    tick();
    chk("t5_pre", rdata, word(0, 8'h05));
    d(0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_en", 32'({dren, drgen}), 0);
    end
    chk("t5_hold", rdata, word(0, 8'h05));
    d(0, 0, 0, 1, 0);
    tick();
    chk("t5_resume", rdata, word(0, 8'h06));
    // watchdog on device 0 never ready
    dev_rdy = 4'hE;
    d(1, 10'h000, 0, 0, 0);
    tick();
    d(0, 0, 0, 0, 0);
    chk("t3_rdy0", 32'(rdy), 0);
    repeat (254) tick();
    chk("t3_rdy254", 32'(rdy), 0);
    chk("t3_err254", 32'(terr), 0);
    tick();
    chk("t3_rdy255", 32'(rdy), 1);
    chk("t3_err255", 32'(terr), 1);
    d(0, 0, 1, 1, 10'h010);
    chk("t3_ren_gated", 32'(dren), 0);
    tick();
    d(0, 0, 0, 1, 0);
    tick();
    chk("t3_subst", rdata, 32'hDEADBEEF);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_clr", 32'(terr), 0);
    dev_rdy = 4'hF;
    tick();
    // unmapped select on the 3-device instance
    d(1, 10'h3F0, 0, 0, 0);
    tick();
    chk("t4_rdy", 32'(rdy3), 1);
    d(0, 0, 1, 1, 10'h3F0);
    chk("t4_ren", 32'(dren3), 0);
    tick();
    d(0, 0, 0, 1, 0);
    tick();
    chk("t4_data", rdata3, 0);
    d(0, 0, 0, 0, 0);
    repeat (300) tick();
    chk("t4_err", 32'(terr3), 0);
    chk("t4_rdy_late", 32'(rdy3), 1);
    // asynchronous reset mid-burst
    d(1, 10'h200, 0, 0, 0);
    tick();
    d(0, 0, 1, 1, 10'h200);
    tick();
    d(0, 0, 1, 1, 10'h201);
    chk("t6_pre_ren", 32'(dren), 32'h4);
    rst = 1'b1;
    #1;
    chk("t6_async_sel", 32'(dren), 32'h1);
    d(0, 0, 0, 0, 0);
    chk("t6_en", 32'({dren, drgen}), 0);
    chk("t6_err", 32'(terr), 0);
    tick();
    rst = 1'b0;
    d(1, 10'h140, 0, 0, 0);
    tick();
    d(0, 0, 1, 1, 10'h141);
    chk("t6_ren1", 32'(dren), 32'h2);
    tick();
    d(0, 0, 0, 1, 0);
    tick();
    chk("t6_data", rdata, word(1, 8'h41));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
